// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  localparam int SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/full_sub.sv
// Single-bit full subtractor: diff = a - b - bin, bout = borrow out.
// Purely combinational; no latency, no flow control.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial a - b - bin using one full_sub cell, LSB first, one bit per cycle.
// Result appears WIDTH edges after an accepted start; start is ignored while busy.
module serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       r_state;
  sub_state_t       w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_next;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             w_d;
  logic             w_bo;

  full_sub u_full_sub (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .bin  (r_borrow),
    .diff (w_d),
    .bout (w_bo)
  );

  // Written as shift-then-insert so WIDTH=1 needs no special slice.
  always_comb begin
    w_res_next            = r_res >> 1;
    w_res_next[WIDTH-1]   = w_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res    <= w_res_next;
          r_borrow <= w_bo;
          r_cnt    <= r_cnt + 1'b1;
          // Outputs load only on the final bit so no partial value is ever visible.
          if (r_cnt == LAST) begin
            r_diff <= w_res_next;
            r_bout <= w_bo;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
    diff = r_diff;
    bout = r_bout;
  end

endmodule
